timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel Game Boy–style timer: one shared 16-bit system counter (DIV in its upper byte) feeding NUM_CH independent TIMA/TMA/TAC channels. Channels increment on falling edges of a selected system-counter bit and reload from TMA one tick late, as real hardware does. Channel 0 maps onto the standard FF04–FF07 registers, and extra channels extend the map upward. It sits on the CPU I/O bus beside the interrupt controller, which receives one request line per channel.

## Interface
- NUM_CH, 1, number of timer channels (1..4)
- BASE_ADDR, 16'hFF04, address of DIV; channel c uses BASE_ADDR+1+3c (TIMA), +2+3c (TMA), +3+3c (TAC)
- I_CLOCK  in  1  system clock
- I_RESET  in  1  asynchronous, active-high reset
- I_TICK  in  1  timer-domain enable, one pulse per 2^22 Hz period; all counting qualified by it
- I_ADDR  in  16  bus address
- IO_DATA  inout  8  bus data; driven only during a mapped read
- I_RE_L  in  1  read strobe, active-low
- I_WE_L  in  1  write strobe, active-low; write takes effect at the I_CLOCK edge while low
- O_TIMER_INTERRUPT  out  NUM_CH  per-channel one-I_CLOCK interrupt request pulse
- O_DIV_DATA  out  8  debug: DIV
- O_SYSCNT  out  16  debug: full system counter

## Operation
- SYSCNT[15:0] increments by 1 on each I_TICK, wraps FFFF→0000. DIV = SYSCNT[15:8].
- Any DIV write clears SYSCNT to 0, whatever the data. DIV reads return SYSCNT[15:8].
- Bit select per TAC[1:0]: 00→SYSCNT[9], 01→SYSCNT[3], 10→SYSCNT[5], 11→SYSCNT[7].
- Per channel, inc_sig = TAC[2] & selected bit. TIMA increments on the I_CLOCK following a 1→0 transition of inc_sig.
- TAC reads return {5'b11111, TAC[2:0]}. TMA and TIMA read and write as full 8 bits.
- Channel FSM states, with transitions:
  - RUN → OVF: increment while TIMA=FF. TIMA becomes 00.
  - OVF: lasts one I_TICK, TIMA reads 00. At the next I_TICK → RELOAD.
  - RELOAD: TIMA ← TMA and O_TIMER_INTERRUPT[c] pulses for one I_CLOCK. Next I_TICK → RUN.
- Boundary rules:
  - TIMA write in OVF: loads the written data, cancels the reload and interrupt, → RUN.
  - TIMA write in RELOAD: ignored, TMA value wins.
  - TMA write in RELOAD: the new data is loaded into TIMA in the same cycle.
  - Increment and TIMA write in the same cycle: the write wins.
- Unmapped addresses and addresses beyond the last channel are not driven.
- I_RESET mid-operation aborts OVF/RELOAD with no interrupt.

## Timing
- Reset values: SYSCNT=0000, TIMA=TMA=00, TAC=0, all FSMs RUN, O_TIMER_INTERRUPT=0, IO_DATA high-Z.
- Read data is combinational from I_ADDR/I_RE_L, with zero-cycle latency.
- A write is visible on a read starting the next I_CLOCK.
- Increment latency: TIMA changes one I_CLOCK after the SYSCNT edge that drops inc_sig.
- Interrupt fires 2 I_TICKs after the FF→00 increment (OVF + RELOAD).
- TAC=05 (bit 3): TIMA increments every 16 ticks. TAC=04 (bit 9): every 1024 ticks.

## Configuration
- TIMER_GLITCH_EN defined:
  - Edge detection runs on inc_sig itself.
  - A DIV write while the selected bit is 1, or a TAC write dropping TAC[2] or changing the select to a 0 bit, produces one spurious increment, as on hardware.
- TIMER_GLITCH_EN undefined:
  - Edge detection runs only on the selected bit, gated by TAC[2].
  - The edge history register is reloaded from the new value on any DIV/TAC write, so writes never increment TIMA.

## Structure
- Shared package `timer_pkg`:
  - address offsets (DIV_OFS=0, TIMA_OFS=1, TMA_OFS=2, TAC_OFS=3, CH_STRIDE=3)
  - TAC select bit-index constants {9,3,5,7}
  - channel state enum {RUN, OVF, RELOAD}
- Sub-module `timer_channel`:
  - one per channel, generated NUM_CH times
  - owns TIMA/TMA/TAC, the edge detector and the FSM
  - takes SYSCNT, the decoded per-register write enables, bus data and the tick; returns register values and its interrupt
- The top level owns SYSCNT, address decode and the tristate read mux.

## Test plan
- Reset, TAC0=05, TMA0=00, TIMA0=FE; run 32 ticks → TIMA0 reaches FF, then 00. Interrupt pulses exactly 2 ticks after the wrap; TIMA0 = 00 afterwards.
- TMA0=AB, TIMA0=FF, TAC0=05; write TIMA0=40 during OVF → no interrupt, TIMA0=40.
- Same setup; write TMA0=CD during RELOAD → TIMA0=CD, one interrupt.
- TIMER_GLITCH_EN:
  - TAC0=05, run until SYSCNT[3]=1, write DIV → TIMA0 +1 immediately, SYSCNT=0000.
  - Without the macro, the same sequence leaves TIMA0 unchanged.
- NUM_CH=2, BASE_ADDR=FF04: write TAC1 at FF0A=04 and TAC0=05 → channel 0 steps every 16 ticks, channel 1 every 1024. Read FF0A → FC. Read FF0D → IO_DATA high-Z.
- Assert I_RESET while channel 0 is in OVF → no interrupt pulse, all registers 00, DIV reads 00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants, channel state encoding and bit-select helper for timer_bank.
package timer_pkg;

    localparam logic [15:0] DIV_OFS   = 16'd0;
    localparam logic [15:0] TIMA_OFS  = 16'd1;
    localparam logic [15:0] TMA_OFS   = 16'd2;
    localparam logic [15:0] TAC_OFS   = 16'd3;
    localparam logic [15:0] CH_STRIDE = 16'd3;

    // SYSCNT bit watched for each TAC[1:0] setting
    localparam logic [3:0] TAC_SEL_BIT [4] = '{4'd9, 4'd3, 4'd5, 4'd7};

    typedef enum logic [1:0] {RUN, OVF, RELOAD} ch_state_t;

    function automatic logic sel_bit(input logic [15:0] cnt, input logic [1:0] sel);
        return cnt[TAC_SEL_BIT[sel]];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One TIMA/TMA/TAC timer channel: falling-edge detector on the selected SYSCNT bit plus the
// overflow/reload sequencer. TIMER_GLITCH_EN selects hardware-accurate write glitches.
module timer_channel
    import timer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] syscnt,
    input  logic [15:0] syscnt_nxt,
    input  logic        div_we,
    input  logic        tima_we,
    input  logic        tma_we,
    input  logic        tac_we,
    input  logic [7:0]  wdata,
    output logic [7:0]  tima,
    output logic [7:0]  tma,
    output logic [2:0]  tac,
    output logic        irq
);

    ch_state_t  state, state_nxt;
    logic [7:0] tima_nxt, tma_nxt;
    logic [2:0] tac_nxt;
    logic       hist, hist_nxt, inc, irq_nxt;

    assign tma_nxt = tma_we ? wdata : tma;
    assign tac_nxt = tac_we ? wdata[2:0] : tac;

`ifdef TIMER_GLITCH_EN
    logic inc_sig;
    assign inc_sig  = tac[2] & sel_bit(syscnt, tac[1:0]);
    assign inc      = hist & ~inc_sig;
    assign hist_nxt = inc_sig;
`else
    logic cur_bit;
    assign cur_bit  = sel_bit(syscnt, tac[1:0]);
    assign inc      = tac[2] & hist & ~cur_bit;
    // Resync history to post-write value so DIV/TAC writes never look like an edge
    assign hist_nxt = (div_we | tac_we) ? sel_bit(syscnt_nxt, tac_nxt[1:0]) : cur_bit;
`endif

    always_comb begin
        state_nxt = state;
        tima_nxt  = tima;
        irq_nxt   = 1'b0;
        case (state)
            RUN: begin
                if (tima_we) begin
                    tima_nxt = wdata;
                end else if (inc) begin
                    if (tima == 8'hFF) begin
                        tima_nxt  = 8'h00;
                        state_nxt = OVF;
                    end else begin
                        tima_nxt = tima + 8'd1;
                    end
                end
            end
            OVF: begin
                if (tima_we) begin
                    tima_nxt  = wdata;
                    state_nxt = RUN;
                end else if (tick) begin
                    tima_nxt  = tma_nxt;
                    state_nxt = RELOAD;
                end
            end
            RELOAD: begin
                // TIMA follows TMA for the whole reload window; TIMA writes are lost
                tima_nxt = tma_nxt;
                if (tick) begin
                    state_nxt = RUN;
                    irq_nxt   = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            tima  <= 8'h00;
            tma   <= 8'h00;
            tac   <= 3'b000;
            hist  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            state <= state_nxt;
            tima  <= tima_nxt;
            tma   <= tma_nxt;
            tac   <= tac_nxt;
            hist  <= hist_nxt;
            irq   <= irq_nxt;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel Game Boy-style timer bank: shared SYSCNT/DIV, bus decode and read mux.
// Optional macro TIMER_GLITCH_EN enables hardware write glitches in the channels.
module timer_bank
    import timer_pkg::*;
#(
    parameter int          NUM_CH    = 1,
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET,
    input  logic              I_TICK,
    input  logic [15:0]       I_ADDR,
    inout  wire  [7:0]        IO_DATA,
    input  logic              I_RE_L,
    input  logic              I_WE_L,
    output logic [NUM_CH-1:0] O_TIMER_INTERRUPT,
    output logic [7:0]        O_DIV_DATA,
    output logic [15:0]       O_SYSCNT
);

    logic [15:0] syscnt, syscnt_nxt, ofs;
    logic        wr, div_we, rd_hit;
    logic [7:0]  wdata, rd_data;
    logic [7:0]  tima_v [NUM_CH];
    logic [7:0]  tma_v  [NUM_CH];
    logic [2:0]  tac_v  [NUM_CH];

    assign ofs        = I_ADDR - BASE_ADDR;
    assign wr         = ~I_WE_L;
    assign wdata      = IO_DATA;
    assign div_we     = wr && (ofs == DIV_OFS);
    assign syscnt_nxt = div_we ? 16'h0000 : (I_TICK ? syscnt + 16'd1 : syscnt);

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) syscnt <= 16'h0000;
        else         syscnt <= syscnt_nxt;
    end

    assign O_SYSCNT   = syscnt;
    assign O_DIV_DATA = syscnt[15:8];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] CH_OFS = CH_STRIDE * 16'(c);
        timer_channel u_ch (
            .clock      (I_CLOCK),
            .reset      (I_RESET),
            .tick       (I_TICK),
            .syscnt     (syscnt),
            .syscnt_nxt (syscnt_nxt),
            .div_we     (div_we),
            .tima_we    (wr && (ofs == TIMA_OFS + CH_OFS)),
            .tma_we     (wr && (ofs == TMA_OFS + CH_OFS)),
            .tac_we     (wr && (ofs == TAC_OFS + CH_OFS)),
            .wdata      (wdata),
            .tima       (tima_v[c]),
            .tma        (tma_v[c]),
            .tac        (tac_v[c]),
            .irq        (O_TIMER_INTERRUPT[c])
        );
    end

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 8'h00;
        if (ofs == DIV_OFS) begin
            rd_hit  = 1'b1;
            rd_data = syscnt[15:8];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ofs == TIMA_OFS + CH_STRIDE * 16'(c)) begin
                rd_hit  = 1'b1;
                rd_data = tima_v[c];
            end
            if (ofs == TMA_OFS + CH_STRIDE * 16'(c)) begin
                rd_hit  = 1'b1;
                rd_data = tma_v[c];
            end
            if (ofs == TAC_OFS + CH_STRIDE * 16'(c)) begin
                rd_hit  = 1'b1;
                rd_data = {5'b11111, tac_v[c]};
            end
        end
    end

    assign IO_DATA = (rd_hit && !I_RE_L) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_timer_bank.sv
// Randomised bench for timer_bank (two channels) against a rule-level reference model.
module tb_timer_bank;

    localparam int          NCH  = 2;
    localparam logic [15:0] BASE = 16'hFF04;

    logic           clk = 1'b0;
    logic           rst, tick, re_l, we_l, drv_en;
    logic [15:0]    addr;
    logic [7:0]     drv_data;
    wire  [7:0]     io_data;
    logic [NCH-1:0] irq;
    logic [7:0]     div_data;
    logic [15:0]    syscnt;

    assign io_data = drv_en ? drv_data : 8'hzz;
    pullup (io_data);

    timer_bank #(.NUM_CH(NCH), .BASE_ADDR(BASE)) dut (
        .I_CLOCK           (clk),
        .I_RESET           (rst),
        .I_TICK            (tick),
        .I_ADDR            (addr),
        .IO_DATA           (io_data),
        .I_RE_L            (re_l),
        .I_WE_L            (we_l),
        .O_TIMER_INTERRUPT (irq),
        .O_DIV_DATA        (div_data),
        .O_SYSCNT          (syscnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: wrap age -1 = counting, 0 = overflowed, 1 = reloading
    logic [15:0]    m_sys;
    logic [7:0]     m_tima [NCH];
    logic [7:0]     m_tma  [NCH];
    logic [2:0]     m_tac  [NCH];
    logic           m_hist [NCH];
    int             m_age  [NCH];
    logic [NCH-1:0] m_irq;
    int             sel_tab [4] = '{9, 3, 5, 7};
    int             irq_seen [NCH];
    logic [7:0]     obs_tima [NCH];
    int             cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [15:0] s, input logic [2:0] t);
        return s[sel_tab[t[1:0]]];
    endfunction

    task automatic m_reset();
        m_sys = 16'h0000;
        m_irq = '0;
        for (int c = 0; c < NCH; c++) begin
            m_tima[c] = 8'h00; m_tma[c] = 8'h00; m_tac[c] = 3'b000;
            m_hist[c] = 1'b0;  m_age[c] = -1;
        end
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE;
        if (o == 16'd0) return m_sys[15:8];
        for (int c = 0; c < NCH; c++) begin
            if (o == 16'(1 + 3 * c)) return m_tima[c];
            if (o == 16'(2 + 3 * c)) return m_tma[c];
            if (o == 16'(3 + 3 * c)) return {5'b11111, m_tac[c]};
        end
        return 8'hFF;
    endfunction

    task automatic m_step(input bit tk, input bit wr, input logic [15:0] a, input logic [7:0] d);
        logic [15:0] o, nsys;
        logic        div_w, tima_w, tma_w, tac_w, b, fall;
        logic [7:0]  ntma;
        logic [2:0]  ntac;
        o     = a - BASE;
        div_w = wr && (o == 16'd0);
        nsys  = div_w ? 16'h0000 : (tk ? m_sys + 16'd1 : m_sys);
        m_irq = '0;
        for (int c = 0; c < NCH; c++) begin
            tima_w = wr && (o == 16'(1 + 3 * c));
            tma_w  = wr && (o == 16'(2 + 3 * c));
            tac_w  = wr && (o == 16'(3 + 3 * c));
            ntma   = tma_w ? d : m_tma[c];
            ntac   = tac_w ? d[2:0] : m_tac[c];
`ifdef TIMER_GLITCH_EN
            b         = m_tac[c][2] & bit_of(m_sys, m_tac[c]);
            fall      = m_hist[c] & ~b;
            m_hist[c] = b;
`else
            b         = bit_of(m_sys, m_tac[c]);
            fall      = m_tac[c][2] & m_hist[c] & ~b;
            m_hist[c] = (div_w | tac_w) ? bit_of(nsys, ntac) : b;
`endif
            if (m_age[c] < 0) begin
                if (tima_w) m_tima[c] = d;
                else if (fall) begin
                    if (m_tima[c] == 8'hFF) begin m_tima[c] = 8'h00; m_age[c] = 0; end
                    else m_tima[c] = m_tima[c] + 8'd1;
                end
            end else if (m_age[c] == 0) begin
                if (tima_w) begin m_tima[c] = d; m_age[c] = -1; end
                else if (tk) begin m_tima[c] = ntma; m_age[c] = 1; end
            end else begin
                m_tima[c] = ntma;
                if (tk) begin m_irq[c] = 1'b1; m_age[c] = -1; end
            end
            m_tma[c] = ntma;
            m_tac[c] = ntac;
        end
        m_sys = nsys;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        addr = a; re_l = 1'b0;
        #1;
        v = io_data;
        re_l = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a);
        logic [7:0] v;
        rd(a, v);
        check(tag, v, m_read(a));
    endtask

    task automatic cycle(input bit tk, input bit wr, input logic [15:0] a, input logic [7:0] d);
        logic [7:0] v;
        tick = tk; addr = a; we_l = ~wr; drv_en = wr; drv_data = d; re_l = 1'b1;
        @(posedge clk);
        m_step(tk, wr, a, d);
        cyc++;
        #1;
        tick = 1'b0; we_l = 1'b1; drv_en = 1'b0;
        check("irq", irq, m_irq);
        check("syscnt", syscnt, m_sys);
        check("div", div_data, m_sys[15:8]);
        for (int c = 0; c < NCH; c++) begin
            irq_seen[c] += int'(irq[c]);
            rd(BASE + 16'(1 + 3 * c), v);
            obs_tima[c] = v;
            check("tima", v, m_read(BASE + 16'(1 + 3 * c)));
        end
        rd_chk("rand_rd", BASE - 16'd1 + 16'($urandom_range(0, 11)));
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic run(input int n, input bit tk);
        for (int i = 0; i < n; i++) cycle(tk, 1'b0, 16'h0000, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        int wrap_cyc, irq_cyc;
        bit found;
        logic [15:0] a;
        logic [7:0] d;

        rst = 1'b1; tick = 1'b0; re_l = 1'b1; we_l = 1'b1; drv_en = 1'b0;
        addr = 16'h0000; drv_data = 8'h00;
        for (int c = 0; c < NCH; c++) begin irq_seen[c] = 0; obs_tima[c] = 8'h00; end
        m_reset();
        #12;
        check("rst_irq", irq, 0);
        check("rst_sys", syscnt, 0);
        rd_chk("rst_div", BASE);
        rd_chk("rst_tima0", BASE + 16'd1);
        rd_chk("rst_tma0", BASE + 16'd2);
        rd(BASE + 16'd3, v);   check("rst_tac0", v, 8'hF8);
        rd(BASE + 16'd9, v);   check("rst_hiz", v, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

        // Overflow and interrupt latency
        wr_reg(BASE, 8'h00);
        wr_reg(BASE + 16'd3, 8'h05);
        wr_reg(BASE + 16'd2, 8'h00);
        wr_reg(BASE + 16'd1, 8'hFE);
        irq_seen[0] = 0; wrap_cyc = -1; irq_cyc = -100;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 16'h0000, 8'h00);
            if (wrap_cyc < 0 && obs_tima[0] == 8'h00) wrap_cyc = cyc;
            if (irq[0]) irq_cyc = cyc;
        end
        check("s1_irq_cnt", irq_seen[0], 1);
        check("s1_irq_lat", irq_cyc - wrap_cyc, 2);
        check("s1_tima", obs_tima[0], 8'h00);

        // TIMA write during OVF cancels reload
        wr_reg(BASE + 16'd2, 8'hAB);
        wr_reg(BASE + 16'd1, 8'hFF);
        irq_seen[0] = 0; found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle(1'b1, 1'b0, 16'h0000, 8'h00);
            found = (m_age[0] == 0);
        end
        check("s2_reach_ovf", found, 1);
        check("s2_ovf_tima", obs_tima[0], 8'h00);
        cycle(1'b1, 1'b1, BASE + 16'd1, 8'h40);
        check("s2_tima", obs_tima[0], 8'h40);
        run(8, 1'b0);
        check("s2_no_irq", irq_seen[0], 0);
        check("s2_tima_hold", obs_tima[0], 8'h40);

        // TMA write during RELOAD lands in TIMA
        wr_reg(BASE + 16'd1, 8'hFF);
        irq_seen[0] = 0; found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle(1'b1, 1'b0, 16'h0000, 8'h00);
            found = (m_age[0] == 1);
        end
        check("s3_reach_reload", found, 1);
        cycle(1'b0, 1'b1, BASE + 16'd2, 8'hCD);
        check("s3_tima", obs_tima[0], 8'hCD);
        run(4, 1'b1);
        check("s3_irq_cnt", irq_seen[0], 1);

        // DIV write while the selected bit is high
        wr_reg(BASE + 16'd1, 8'h10);
        for (int i = 0; i < 32 && !syscnt[3]; i++) cycle(1'b1, 1'b0, 16'h0000, 8'h00);
        check("s4_bit3", syscnt[3], 1);
        wr_reg(BASE, 8'h5A);
        check("s4_sys", syscnt, 16'h0000);
        run(2, 1'b0);
`ifdef TIMER_GLITCH_EN
        check("s4_tima", obs_tima[0], 8'h11);
`else
        check("s4_tima", obs_tima[0], 8'h10);
`endif

        // Two channels at different rates
        wr_reg(BASE + 16'd3, 8'h05);
        wr_reg(BASE + 16'd6, 8'h04);
        wr_reg(BASE, 8'h00);
        wr_reg(BASE + 16'd1, 8'h00);
        wr_reg(BASE + 16'd4, 8'h00);
        run(2048, 1'b1);
        run(1, 1'b0);
        check("s5_tima0", obs_tima[0], 8'h80);
        check("s5_tima1", obs_tima[1], 8'h02);
        rd(16'hFF0A, v); check("s5_tac1", v, 8'hFC);
        rd(16'hFF0D, v); check("s5_hiz", v, 8'hFF);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            a = BASE + 16'($urandom_range(0, 9));
            d = 8'($urandom);
            if ((a - BASE) % 16'd3 == 16'd1) d = 8'($urandom_range(8'hF0, 8'hFF));
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), a, d);
        end

        // Reset while overflowed
        wr_reg(BASE + 16'd3, 8'h05);
        wr_reg(BASE + 16'd2, 8'h77);
        wr_reg(BASE + 16'd1, 8'hFF);
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle(1'b1, 1'b0, 16'h0000, 8'h00);
            found = (m_age[0] == 0);
        end
        check("s6_reach_ovf", found, 1);
        irq_seen[0] = 0;
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        check("s6_irq", irq, 0);
        check("s6_sys", syscnt, 16'h0000);
        rd(BASE, v);           check("s6_div", v, 8'h00);
        rd(BASE + 16'd1, v);   check("s6_tima0", v, 8'h00);
        rd(BASE + 16'd2, v);   check("s6_tma0", v, 8'h00);
        rd(BASE + 16'd3, v);   check("s6_tac0", v, 8'hF8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(6, 1'b1);
        check("s6_no_irq", irq_seen[0], 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
